// File: rtl/booth8_sequencer.sv
// rtl/booth8_sequencer.sv - radix-8 Booth control sequencer (optional zero-digit skip: BOOTH8_ZERO_SKIP_EN)
module booth8_sequencer #(
  parameter int  WIDTH  = 8,
  parameter int  SIGNED = 1,
  localparam int NDIG   = (SIGNED != 0) ? (WIDTH + 2) / 3 : (WIDTH + 3) / 3,
  localparam int DW     = (NDIG > 2) ? $clog2(NDIG) : 1
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Start,
  input  logic [WIDTH-1:0] B,
  output logic [2:0]       Si,
  output logic [2:0]       Mag,
  output logic [DW-1:0]    Digit,
  output logic             Busy,
  output logic             Done
);

  localparam int RW = 3 * NDIG + 1;

  localparam logic [2:0] SI_IDLE  = 3'b000;
  localparam logic [2:0] SI_ADD   = 3'b001;
  localparam logic [2:0] SI_ADDC  = 3'b010;
  localparam logic [2:0] SI_LOAD  = 3'b011;
  localparam logic [2:0] SI_SHIFT = 3'b100;

  localparam logic [DW-1:0] LAST_DIG = DW'(NDIG - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ADD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] r_q, r_d;
  logic [DW-1:0] digit_q, digit_d;
  logic [2:0]    si_q, si_d;
  logic [2:0]    mag_q, mag_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // Captured multiplier with the implicit b(-1)=0 below bit 0; the extension
  // to RW bits absorbs widths that are not a multiple of three.
  logic [RW-1:0] cap_s, cap_u, cap;
  assign cap_s = RW'($signed({B, 1'b0}));
  assign cap_u = RW'({B, 1'b0});
  assign cap   = (SIGNED != 0) ? cap_s : cap_u;

  logic [DW-1:0] nxt_idx;
  logic [DW+1:0] shamt;
  logic [3:0]    win;
  logic [3:0]    dec;
  logic          enter_digit;

  // Recode a 4-bit overlapping window into {negative, magnitude}.
  function automatic logic [3:0] booth_dec(input logic [3:0] w);
    case (w)
      4'b0000, 4'b1111: return 4'b0_000;
      4'b0001, 4'b0010: return 4'b0_001;
      4'b0011, 4'b0100: return 4'b0_010;
      4'b0101, 4'b0110: return 4'b0_011;
      4'b0111:          return 4'b0_100;
      4'b1000:          return 4'b1_100;
      4'b1001, 4'b1010: return 4'b1_011;
      4'b1011, 4'b1100: return 4'b1_010;
      4'b1101, 4'b1110: return 4'b1_001;
      default:          return 4'b0_000;
    endcase
  endfunction

  assign shamt = {1'b0, nxt_idx, 1'b0} + {2'b00, nxt_idx};
  assign win   = r_q[shamt +: 4];
  assign dec   = booth_dec(win);

  // Next-state logic; outputs are precomputed from the next state so they leave flops.
  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    digit_d     = digit_q;
    nxt_idx     = digit_q;
    enter_digit = 1'b0;

    case (state_q)
      S_IDLE: begin
        digit_d = '0;
        if (Start) begin
          state_d = S_LOAD;
          r_d     = cap;
        end
      end
      S_LOAD: begin
        nxt_idx     = '0;
        digit_d     = '0;
        enter_digit = 1'b1;
      end
      S_ADD: begin
        state_d = (digit_q == LAST_DIG) ? S_DONE : S_SHIFT;
      end
      S_SHIFT: begin
        nxt_idx     = digit_q + 1'b1;
        digit_d     = nxt_idx;
        enter_digit = 1'b1;
      end
      S_DONE: begin
        state_d = S_IDLE;
        digit_d = '0;
      end
      default: begin
        state_d = S_IDLE;
        digit_d = '0;
      end
    endcase

    if (enter_digit) begin
      state_d = S_ADD;
`ifdef BOOTH8_ZERO_SKIP_EN
      // A zero digit needs no datapath work: take its slot as the following step.
      if (dec[2:0] == 3'd0) begin
        state_d = (nxt_idx == LAST_DIG) ? S_DONE : S_SHIFT;
      end
`endif
    end

    si_d   = SI_IDLE;
    mag_d  = 3'd0;
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_d)
      S_LOAD: begin
        si_d   = SI_LOAD;
        busy_d = 1'b1;
      end
      S_ADD: begin
        si_d   = dec[3] ? SI_ADDC : SI_ADD;
        mag_d  = dec[2:0];
        busy_d = 1'b1;
      end
      S_SHIFT: begin
        si_d   = SI_SHIFT;
        busy_d = 1'b1;
      end
      S_DONE: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: begin
        si_d = SI_IDLE;
      end
    endcase
  end

  // State, captured multiplier and registered outputs; reset aborts instantly.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      digit_q <= '0;
      si_q    <= SI_IDLE;
      mag_q   <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      digit_q <= digit_d;
      si_q    <= si_d;
      mag_q   <= mag_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Si    = si_q;
  assign Mag   = mag_q;
  assign Digit = digit_q;
  assign Busy  = busy_q;
  assign Done  = done_q;

endmodule

// File: tb/tb_booth8_sequencer.sv
// tb/tb_booth8_sequencer.sv - directed vector bench for booth8_sequencer
module tb_booth8_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       st0, st1, st2;
  logic [7:0] b0, b1;
  logic [8:0] b2;
  logic [2:0] si0, si1, si2, mag0, mag1, mag2;
  logic [1:0] dg0, dg1, dg2;
  logic       bz0, bz1, bz2, dn0, dn1, dn2;

  booth8_sequencer #(.WIDTH(8), .SIGNED(1)) dut_8s (
    .Clock(clk), .Resetn(rst_n), .Start(st0), .B(b0),
    .Si(si0), .Mag(mag0), .Digit(dg0), .Busy(bz0), .Done(dn0));

  booth8_sequencer #(.WIDTH(8), .SIGNED(0)) dut_8u (
    .Clock(clk), .Resetn(rst_n), .Start(st1), .B(b1),
    .Si(si1), .Mag(mag1), .Digit(dg1), .Busy(bz1), .Done(dn1));

  booth8_sequencer #(.WIDTH(9), .SIGNED(0)) dut_9u (
    .Clock(clk), .Resetn(rst_n), .Start(st2), .B(b2),
    .Si(si2), .Mag(mag2), .Digit(dg2), .Busy(bz2), .Done(dn2));

  // Observed command code: Si*16 + Mag*2 + Done
  localparam int LOAD_C  = 48;
  localparam int SHIFT_C = 64;
  localparam int DONE_C  = 1;

  typedef struct {
    int    inst;
    int    b;
    string seq;
  } vec_t;

  vec_t vecs[$];
  int   exp_q[$];
  int   checks = 0;
  int   passed = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: actual %0d required %0d", name, act, exp);
  endtask

  task automatic set_start(input int inst, input logic s);
    case (inst)
      0: st0 = s;
      1: st1 = s;
      default: st2 = s;
    endcase
  endtask

  task automatic set_b(input int inst, input int b);
    logic [8:0] v;
    v = 9'(b);
    case (inst)
      0: b0 = v[7:0];
      1: b1 = v[7:0];
      default: b2 = v;
    endcase
  endtask

  task automatic obs(input int inst, output int code, output int dig, output int bz);
    case (inst)
      0: begin code = int'(si0) * 16 + int'(mag0) * 2 + int'(dn0); dig = int'(dg0); bz = int'(bz0); end
      1: begin code = int'(si1) * 16 + int'(mag1) * 2 + int'(dn1); dig = int'(dg1); bz = int'(bz1); end
      default: begin code = int'(si2) * 16 + int'(mag2) * 2 + int'(dn2); dig = int'(dg2); bz = int'(bz2); end
    endcase
  endtask

  // Expected sequences are written for the fixed-latency build; the skip
  // build simply omits the Add/0 slots.
  task automatic parse(input string s);
    int i;
    int m;
    byte c;
    exp_q.delete();
    i = 0;
    while (i < s.len()) begin
      c = s[i];
      if (c == "L") exp_q.push_back(LOAD_C);
      else if (c == "S") exp_q.push_back(SHIFT_C);
      else if (c == "D") exp_q.push_back(DONE_C);
      else begin
        i++;
        m = int'(s[i]) - 48;
`ifdef BOOTH8_ZERO_SKIP_EN
        if (!(c == "A" && m == 0))
          exp_q.push_back(((c == "A") ? 16 : 32) + m * 2);
`else
        exp_q.push_back(((c == "A") ? 16 : 32) + m * 2);
`endif
      end
      i++;
    end
  endtask

  task automatic run_seq(input int inst, input int b, input string s,
                         input int pulse_at, input bit hold, input string tag);
    int code, dig, bz, sh, cyc;
    parse(s);
    set_b(inst, b);
    set_start(inst, 1'b1);
    @(negedge clk);
    if (!hold) set_start(inst, 1'b0);
    set_b(inst, b ^ 'h155);
    sh = 0;
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k > 0) @(negedge clk);
      if (pulse_at >= 0 && k == pulse_at + 1) set_start(inst, 1'b0);
      obs(inst, code, dig, bz);
      check($sformatf("%s step%0d cmd", tag, k), code, exp_q[k]);
      check($sformatf("%s step%0d busy", tag, k), bz, 1);
      if (exp_q[k] != DONE_C) check($sformatf("%s step%0d digit", tag, k), dig, sh);
      if (exp_q[k] == SHIFT_C) sh++;
      if (k == pulse_at) set_start(inst, 1'b1);
    end
    @(negedge clk);
    obs(inst, code, dig, bz);
    check($sformatf("%s idle cmd", tag), code, 0);
    check($sformatf("%s idle busy", tag), bz, 0);
    check($sformatf("%s idle digit", tag), dig, 0);
    if (hold) begin
      @(negedge clk);
      obs(inst, code, dig, bz);
      check($sformatf("%s restart load", tag), code, LOAD_C);
      check($sformatf("%s restart busy", tag), bz, 1);
      set_start(inst, 1'b0);
      cyc = 0;
      while (bz != 0 && cyc < 30) begin
        @(negedge clk);
        obs(inst, code, dig, bz);
        cyc++;
      end
      check($sformatf("%s drain busy", tag), bz, 0);
    end
  endtask

  initial begin
    int code, dig, bz;
    rst_n = 1'b0;
    st0 = 1'b0; st1 = 1'b0; st2 = 1'b0;
    b0 = '0; b1 = '0; b2 = '0;

    vecs.push_back('{0, 30,     "LC2SA4SA0D"});
    vecs.push_back('{0, 'hFF,   "LC1SA0SA0D"});
    vecs.push_back('{0, 'h80,   "LA0SA0SC2D"});
    vecs.push_back('{0, 5,      "LC3SA1SA0D"});
    vecs.push_back('{0, 127,    "LC1SA0SA2D"});
    vecs.push_back('{1, 128,    "LA0SA0SA2D"});
    vecs.push_back('{1, 255,    "LC1SA0SA4D"});
    vecs.push_back('{2, 'h1FF,  "LC1SA0SA0SA1D"});
    vecs.push_back('{2, 171,    "LA3SC3SA3SA0D"});

    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      obs(i, code, dig, bz);
      check($sformatf("reset inst%0d cmd", i), code, 0);
      check($sformatf("reset inst%0d digit", i), dig, 0);
      check($sformatf("reset inst%0d busy", i), bz, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++)
      run_seq(vecs[i].inst, vecs[i].b, vecs[i].seq, -1, 1'b0, $sformatf("vec%0d", i));

    run_seq(0, 30, "LC2SA4SA0D", 3, 1'b0, "pulse_busy");
    run_seq(0, 30, "LC2SA4SA0D", -1, 1'b1, "start_held");

    // Abort during the second Shift
    set_b(0, 30);
    set_start(0, 1'b1);
    @(negedge clk);
    set_start(0, 1'b0);
    repeat (4) @(negedge clk);
    obs(0, code, dig, bz);
    check("abort pre shift", code, SHIFT_C);
    rst_n = 1'b0;
    #1;
    obs(0, code, dig, bz);
    check("abort cmd", code, 0);
    check("abort digit", dig, 0);
    check("abort busy", bz, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      obs(0, code, dig, bz);
      check($sformatf("abort hold%0d done", k), code % 2, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    obs(0, code, dig, bz);
    check("abort released cmd", code, 0);
    check("abort released busy", bz, 0);
    run_seq(0, 30, "LC2SA4SA0D", -1, 1'b0, "post_abort");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
